rob_multi_commit: RTL and testbench

- Parametrised reorder buffer for the out-of-order RISC-V core; successor to the single-entry rob_data bookkeeping.
- Allocates one entry per cycle from rename and accepts completions from CPL_PORTS functional units (ALU, MEM, BR).
- Retires up to COMMIT_W entries per cycle in order.
- On branch mispredict, walks the tail back one entry per cycle and streams squashed entries to rename for map-table and free-list recovery.

---
 rtl/rob_multi_commit.sv | 162 ++++++++++++++++
 tb/tb_rob_multi_commit.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_multi_commit.sv
// In-order retire reorder buffer: one alloc/cycle, CPL_PORTS completions, up to COMMIT_W commits/cycle.
// Commit outputs are combinational from state; a mispredict walks the tail back one squashed entry per cycle.
module rob_multi_commit #(
  parameter int DEPTH     = 32,
  parameter int TAG_W     = $clog2(DEPTH),
  parameter int PREG_W    = 7,
  parameter int PC_W      = 32,
  parameter int COMMIT_W  = 2,
  parameter int CPL_PORTS = 3
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        alloc_valid,
  input  logic [PREG_W-1:0]           alloc_pd_new,
  input  logic [PREG_W-1:0]           alloc_pd_old,
  input  logic [PC_W-1:0]             alloc_pc,
  output logic                        alloc_ready,
  output logic [TAG_W-1:0]            alloc_tag,
  input  logic [CPL_PORTS-1:0]        cpl_valid,
  input  logic [CPL_PORTS*TAG_W-1:0]  cpl_tag,
  input  logic                        mispredict,
  input  logic [TAG_W-1:0]            mispredict_tag,
  output logic [COMMIT_W-1:0]         commit_valid,
  output logic [COMMIT_W*PREG_W-1:0]  commit_pd_old,
  output logic [COMMIT_W*PREG_W-1:0]  commit_pd_new,
  output logic [COMMIT_W*PC_W-1:0]    commit_pc,
  output logic                        rec_valid,
  output logic [PREG_W-1:0]           rec_pd_new,
  output logic [PREG_W-1:0]           rec_pd_old,
  output logic                        busy_recover,
  output logic [TAG_W:0]              count
);

  localparam logic [TAG_W:0] FULL = (TAG_W+1)'(DEPTH);

  typedef struct packed {
    logic [PREG_W-1:0] pd_new;
    logic [PREG_W-1:0] pd_old;
    logic [PC_W-1:0]   pc;
  } entry_t;

  typedef enum logic {IDLE = 1'b0, RECOVER = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [TAG_W-1:0]    head, tail, tgt, tgt_nxt;
  logic [TAG_W:0]      cnt;
  logic [DEPTH-1:0]    vld, cmp, vld_nxt, cmp_nxt;
  entry_t              mem [DEPTH];

  logic                alloc_fire, rec_fire;
  logic [TAG_W-1:0]    tail_m1, tail_m2, age_mp, age_tgt;
  logic [TAG_W-1:0]    cidx [COMMIT_W];
  logic [COMMIT_W-1:0] fire;
  logic [TAG_W:0]      n_commit;

  assign tail_m1      = tail - TAG_W'(1);
  assign tail_m2      = tail - TAG_W'(2);
  assign age_mp       = mispredict_tag - head;
  assign age_tgt      = tgt - head;

  assign alloc_ready  = (state == IDLE) && (cnt < FULL) && !mispredict;
  assign alloc_fire   = alloc_valid && alloc_ready;
  assign alloc_tag    = tail;
  assign rec_fire     = (state == RECOVER);
  assign busy_recover = rec_fire;
  assign rec_valid    = rec_fire;
  assign rec_pd_new   = rec_fire ? mem[tail_m1].pd_new : '0;
  assign rec_pd_old   = rec_fire ? mem[tail_m1].pd_old : '0;
  assign count        = cnt;

  // Retire slots form a prefix: one unfinished entry blocks everything younger.
  always_comb begin : commit_sel
    logic chain;
    chain         = (state == IDLE);
    n_commit      = '0;
    fire          = '0;
    commit_pd_old = '0;
    commit_pd_new = '0;
    commit_pc     = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      cidx[i] = head + TAG_W'(i);
      chain   = chain && (cnt > (TAG_W+1)'(i)) && vld[cidx[i]] && cmp[cidx[i]];
      fire[i] = chain;
      if (chain) begin
        n_commit                          = n_commit + (TAG_W+1)'(1);
        commit_pd_old[i*PREG_W +: PREG_W] = mem[cidx[i]].pd_old;
        commit_pd_new[i*PREG_W +: PREG_W] = mem[cidx[i]].pd_new;
        commit_pc[i*PC_W +: PC_W]         = mem[cidx[i]].pc;
      end
    end
    commit_valid = fire;
  end

  // The walk stops once the entry just above the target has been squashed.
  always_comb begin
    state_nxt = state;
    tgt_nxt   = tgt;
    case (state)
      IDLE: begin
        if (mispredict && vld[mispredict_tag]) begin
          tgt_nxt = mispredict_tag;
          if (tail_m1 != mispredict_tag) state_nxt = RECOVER;
        end
      end
      RECOVER: begin
        if (mispredict && vld[mispredict_tag] && (age_mp < age_tgt)) tgt_nxt = mispredict_tag;
        if (tail_m2 == tgt_nxt) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    vld_nxt = vld;
    cmp_nxt = cmp;
    for (int p = 0; p < CPL_PORTS; p++) begin
      if (cpl_valid[p] && vld[cpl_tag[p*TAG_W +: TAG_W]])
        cmp_nxt[cpl_tag[p*TAG_W +: TAG_W]] = 1'b1;
    end
    for (int i = 0; i < COMMIT_W; i++) begin
      if (fire[i]) begin
        vld_nxt[cidx[i]] = 1'b0;
        cmp_nxt[cidx[i]] = 1'b0;
      end
    end
    if (rec_fire) begin
      vld_nxt[tail_m1] = 1'b0;
      cmp_nxt[tail_m1] = 1'b0;
    end
    if (alloc_fire) begin
      vld_nxt[tail] = 1'b1;
      cmp_nxt[tail] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      tgt   <= '0;
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
      vld   <= '0;
      cmp   <= '0;
    end else begin
      state <= state_nxt;
      tgt   <= tgt_nxt;
      head  <= head + n_commit[TAG_W-1:0];
      cnt   <= cnt + (TAG_W+1)'(alloc_fire) - n_commit - (TAG_W+1)'(rec_fire);
      vld   <= vld_nxt;
      cmp   <= cmp_nxt;
      if (alloc_fire)    tail <= tail + TAG_W'(1);
      else if (rec_fire) tail <= tail_m1;
    end
  end

  // Payload needs no reset: every read is qualified by a valid bit or state.
  always_ff @(posedge clk) begin
    if (alloc_fire) mem[tail] <= entry_t'{pd_new: alloc_pd_new, pd_old: alloc_pd_old, pc: alloc_pc};
  end

endmodule

// File: tb/tb_rob_multi_commit.sv
// Directed bench for rob_multi_commit: a queue-based ROB model is compared against every output each cycle,
// plus literal expectations at the interesting points.
module tb_rob_multi_commit;

  localparam int DEPTH = 32;
  localparam int TW    = 5;
  localparam int PW    = 7;
  localparam int CW    = 2;
  localparam int NP    = 3;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           alloc_valid;
  logic [PW-1:0]  alloc_pd_new, alloc_pd_old;
  logic [31:0]    alloc_pc;
  logic           alloc_ready;
  logic [TW-1:0]  alloc_tag;
  logic [NP-1:0]  cpl_valid;
  logic [NP*TW-1:0] cpl_tag;
  logic           mispredict;
  logic [TW-1:0]  mispredict_tag;
  logic [CW-1:0]  commit_valid;
  logic [CW*PW-1:0] commit_pd_old, commit_pd_new;
  logic [CW*32-1:0] commit_pc;
  logic           rec_valid;
  logic [PW-1:0]  rec_pd_new, rec_pd_old;
  logic           busy_recover;
  logic [TW:0]    count;

  rob_multi_commit #(.DEPTH(DEPTH), .TAG_W(TW), .PREG_W(PW), .PC_W(32), .COMMIT_W(CW), .CPL_PORTS(NP)) dut (
    .clk(clk), .reset_n(reset_n),
    .alloc_valid(alloc_valid), .alloc_pd_new(alloc_pd_new), .alloc_pd_old(alloc_pd_old), .alloc_pc(alloc_pc),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cpl_valid(cpl_valid), .cpl_tag(cpl_tag),
    .mispredict(mispredict), .mispredict_tag(mispredict_tag),
    .commit_valid(commit_valid), .commit_pd_old(commit_pd_old), .commit_pd_new(commit_pd_new), .commit_pc(commit_pc),
    .rec_valid(rec_valid), .rec_pd_new(rec_pd_new), .rec_pd_old(rec_pd_old),
    .busy_recover(busy_recover), .count(count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: live entries oldest-first in a queue; the head tag locates them in tag space.
  typedef struct {
    int          tag;
    int          pd_new;
    int          pd_old;
    int unsigned pc;
    bit          done;
  } ment_t;

  ment_t q[$];
  int    m_head;
  bit    m_rec;
  int    m_tgt;

  function automatic int m_find(input int t);
    foreach (q[j]) if (q[j].tag == t) return j;
    return -1;
  endfunction

  function automatic int m_age(input int t);
    return (t - m_head + DEPTH) % DEPTH;
  endfunction

  function automatic int m_ncommit();
    int n = 0;
    if (m_rec) return 0;
    while (n < CW && n < q.size() && q[n].done) n++;
    return n;
  endfunction

  task automatic model_reset();
    q.delete();
    m_head = 0;
    m_rec  = 0;
    m_tgt  = 0;
  endtask

  task automatic model_step();
    int    n, idx, atag;
    bit    afire, was_rec;
    ment_t e;
    if (!reset_n) begin
      model_reset();
      return;
    end
    n       = m_ncommit();
    atag    = (m_head + q.size()) % DEPTH;
    afire   = alloc_valid && !m_rec && q.size() < DEPTH && !mispredict;
    was_rec = m_rec;
    if (mispredict) begin
      idx = m_find(int'(mispredict_tag));
      if (idx >= 0) begin
        if (!was_rec) begin
          m_tgt = int'(mispredict_tag);
          m_rec = (idx != q.size() - 1);
        end else if (m_age(int'(mispredict_tag)) < m_age(m_tgt)) begin
          m_tgt = int'(mispredict_tag);
        end
      end
    end
    for (int p = 0; p < NP; p++)
      if (cpl_valid[p])
        foreach (q[j]) if (q[j].tag == int'(cpl_tag[p*TW +: TW])) q[j].done = 1'b1;
    if (was_rec) begin
      void'(q.pop_back());
      if (q.size() == 0 || q[q.size()-1].tag == m_tgt) m_rec = 0;
    end
    repeat (n) void'(q.pop_front());
    m_head = (m_head + n) % DEPTH;
    if (afire) begin
      e.tag = atag; e.pd_new = int'(alloc_pd_new); e.pd_old = int'(alloc_pd_old);
      e.pc = alloc_pc; e.done = 1'b0;
      q.push_back(e);
    end
  endtask

  task automatic compare_all();
    int n = m_ncommit();
    chk("alloc_ready", 64'(alloc_ready), 64'(!m_rec && q.size() < DEPTH && !mispredict));
    chk("alloc_tag", 64'(alloc_tag), 64'((m_head + q.size()) % DEPTH));
    chk("count", 64'(count), 64'(q.size()));
    chk("busy_recover", 64'(busy_recover), 64'(m_rec));
    chk("commit_valid", 64'(commit_valid), 64'((1 << n) - 1));
    for (int i = 0; i < CW; i++) begin
      chk("commit_pd_old", 64'(commit_pd_old[i*PW +: PW]), (i < n) ? 64'(q[i].pd_old) : 64'(0));
      chk("commit_pd_new", 64'(commit_pd_new[i*PW +: PW]), (i < n) ? 64'(q[i].pd_new) : 64'(0));
      chk("commit_pc", 64'(commit_pc[i*32 +: 32]), (i < n) ? 64'(q[i].pc) : 64'(0));
    end
    chk("rec_valid", 64'(rec_valid), 64'(m_rec));
    chk("rec_pd_new", 64'(rec_pd_new), m_rec ? 64'(q[q.size()-1].pd_new) : 64'(0));
    chk("rec_pd_old", 64'(rec_pd_old), m_rec ? 64'(q[q.size()-1].pd_old) : 64'(0));
  endtask

  // Inputs are stable from posedge+1 through the next posedge; outputs are checked at negedge.
  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_in();
    alloc_valid = 0; alloc_pd_new = '0; alloc_pd_old = '0; alloc_pc = '0;
    cpl_valid = '0; cpl_tag = '0; mispredict = 0; mispredict_tag = '0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    model_reset();
    tick();
    reset_n = 1;
    tick();
  endtask

  task automatic alloc_n(input int n, input int base_new, input int base_old);
    for (int k = 0; k < n; k++) begin
      alloc_valid  = 1;
      alloc_pd_new = PW'(base_new + k);
      alloc_pd_old = PW'(base_old + k);
      alloc_pc     = 32'h1000 + 32'(4 * (base_new + k));
      tick();
    end
    alloc_valid = 0;
  endtask

  task automatic set_cpl(input int p, input int t);
    cpl_valid[p]         = 1'b1;
    cpl_tag[p*TW +: TW]  = TW'(t);
  endtask

  task automatic set_mp(input int t);
    mispredict     = 1;
    mispredict_tag = TW'(t);
  endtask

  initial begin
    idle_in();
    reset_n = 0;
    model_reset();
    repeat (2) tick();
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_alloc_ready", 64'(alloc_ready), 64'(1));
    chk("rst_commit_valid", 64'(commit_valid), 64'(0));
    chk("rst_rec_valid", 64'(rec_valid), 64'(0));
    reset_n = 1;
    tick();

    // Two completions in one cycle retire together next cycle.
    alloc_n(4, 32, 1);
    set_cpl(0, 1); set_cpl(2, 0);
    #1 chk("cpl_not_yet_visible", 64'(commit_valid), 64'(0));
    tick();
    cpl_valid = '0;
    #1 chk("t1_commit_valid", 64'(commit_valid), 64'(2'b11));
    chk("t1_pd_old0", 64'(commit_pd_old[0 +: PW]), 64'(1));
    chk("t1_pd_old1", 64'(commit_pd_old[PW +: PW]), 64'(2));
    chk("t1_pd_new0", 64'(commit_pd_new[0 +: PW]), 64'(32));
    chk("t1_count_before", 64'(count), 64'(4));
    tick();
    #1 chk("t1_count_after", 64'(count), 64'(2));

    // Younger completion waits for the older one.
    set_cpl(1, 3);
    tick();
    cpl_valid = '0;
    #1 chk("t2_blocked", 64'(commit_valid), 64'(0));
    tick();
    #1 chk("t2_still_blocked", 64'(commit_valid), 64'(0));
    set_cpl(0, 2);
    tick();
    cpl_valid = '0;
    #1 chk("t2_commit_valid", 64'(commit_valid), 64'(2'b11));
    chk("t2_pd_old0", 64'(commit_pd_old[0 +: PW]), 64'(3));
    chk("t2_pd_old1", 64'(commit_pd_old[PW +: PW]), 64'(4));
    tick();
    #1 chk("t2_empty", 64'(count), 64'(0));

    // Full buffer, wrap of the tail, recovery across the wrap.
    do_reset();
    alloc_n(32, 64, 0);
    #1 chk("full_ready", 64'(alloc_ready), 64'(0));
    chk("full_count", 64'(count), 64'(32));
    chk("full_tag_wrapped", 64'(alloc_tag), 64'(0));
    alloc_valid = 1;
    tick();
    alloc_valid = 0;
    #1 chk("full_no_accept", 64'(count), 64'(32));
    set_cpl(1, 0);
    tick();
    cpl_valid = '0;
    #1 chk("full_commit1", 64'(commit_valid), 64'(2'b01));
    tick();
    #1 chk("after_commit_ready", 64'(alloc_ready), 64'(1));
    chk("after_commit_tag", 64'(alloc_tag), 64'(0));
    chk("after_commit_count", 64'(count), 64'(31));
    alloc_n(1, 100, 50);
    #1 chk("refill_count", 64'(count), 64'(32));
    set_mp(30);
    #1 chk("mp_blocks_alloc", 64'(alloc_ready), 64'(0));
    tick();
    mispredict = 0;
    #1 chk("wrap_rec0", 64'(rec_pd_new), 64'(100));
    tick();
    #1 chk("wrap_rec1", 64'(rec_pd_new), 64'(95));
    tick();
    #1 chk("wrap_idle", 64'(busy_recover), 64'(0));
    chk("wrap_count", 64'(count), 64'(30));
    chk("wrap_alloc_tag", 64'(alloc_tag), 64'(31));

    // Ten entries, squash back to tag 3.
    do_reset();
    alloc_n(10, 40, 10);
    set_mp(3);
    tick();
    mispredict = 0;
    for (int k = 0; k < 6; k++) begin
      #1 chk("rec3_busy", 64'(busy_recover), 64'(1));
      chk("rec3_pd_new", 64'(rec_pd_new), 64'(49 - k));
      tick();
    end
    #1 chk("rec3_done", 64'(busy_recover), 64'(0));
    chk("rec3_count", 64'(count), 64'(4));
    chk("rec3_alloc_tag", 64'(alloc_tag), 64'(4));

    // Retarget to an older branch mid-walk; a younger mispredict is ignored.
    do_reset();
    alloc_n(10, 40, 10);
    set_mp(6);
    tick();
    set_mp(2);
    set_cpl(2, 1);
    #1 chk("rt_rec9", 64'(rec_pd_new), 64'(49));
    tick();
    cpl_valid = '0;
    set_mp(8);
    #1 chk("rt_rec8", 64'(rec_pd_new), 64'(48));
    tick();
    mispredict = 0;
    for (int k = 0; k < 5; k++) begin
      #1 chk("rt_busy", 64'(busy_recover), 64'(1));
      chk("rt_pd_new", 64'(rec_pd_new), 64'(47 - k));
      tick();
    end
    #1 chk("rt_done", 64'(busy_recover), 64'(0));
    chk("rt_count", 64'(count), 64'(3));
    chk("rt_alloc_tag", 64'(alloc_tag), 64'(3));
    chk("rt_no_commit", 64'(commit_valid), 64'(0));
    set_cpl(0, 0);
    tick();
    cpl_valid = '0;
    #1 chk("rt_commit2", 64'(commit_valid), 64'(2'b11));
    chk("rt_commit_pd_new1", 64'(commit_pd_new[PW +: PW]), 64'(41));
    tick();
    set_cpl(1, 2);
    tick();
    cpl_valid = '0;
    #1 chk("rt_commit_last", 64'(commit_pd_new[0 +: PW]), 64'(42));
    tick();
    #1 chk("rt_empty", 64'(count), 64'(0));

    // Mispredict when empty, on the youngest entry, and on an unallocated tag.
    do_reset();
    set_mp(0);
    tick();
    mispredict = 0;
    #1 chk("mp_empty_ignored", 64'(busy_recover), 64'(0));
    alloc_n(3, 20, 5);
    set_mp(2);
    tick();
    mispredict = 0;
    #1 chk("mp_youngest_idle", 64'(busy_recover), 64'(0));
    chk("mp_youngest_count", 64'(count), 64'(3));
    set_mp(7);
    tick();
    mispredict = 0;
    #1 chk("mp_invalid_ignored", 64'(busy_recover), 64'(0));

    // Reset in the middle of a walk.
    set_mp(0);
    tick();
    mispredict = 0;
    #1 chk("mid_rec_busy", 64'(busy_recover), 64'(1));
    reset_n = 0;
    model_reset();
    #1 chk("abort_count", 64'(count), 64'(0));
    chk("abort_rec_valid", 64'(rec_valid), 64'(0));
    chk("abort_ready", 64'(alloc_ready), 64'(1));
    chk("abort_busy", 64'(busy_recover), 64'(0));
    tick();
    reset_n = 1;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
